// File: rtl/timer_oneshot_handshake.sv
// One-shot countdown timer with valid/ready handshakes on both sides.
// A period word accepted in IDLE is counted down once per clock; reaching
// zero raises an expiry token that is held until the consumer takes it.
// abort cancels timing or a pending token; clear resets everything.
module timer_oneshot_handshake #(
  parameter int WORD_WIDTH = 20
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  period_valid,
  output logic                  period_ready,
  input  logic [WORD_WIDTH-1:0] period,
  input  logic                  abort,
  output logic                  expired_valid,
  input  logic                  expired_ready,
  output logic                  running,
  output logic [WORD_WIDTH-1:0] remaining,
  output logic [WORD_WIDTH-1:0] expired_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WORD_WIDTH-1:0] ZERO = '0;
  localparam logic [WORD_WIDTH-1:0] ONE  = {{(WORD_WIDTH-1){1'b0}}, 1'b1};

  state_t                  state;
  logic                    running_q;
  logic                    expired_valid_q;
  logic [WORD_WIDTH-1:0]   remaining_q;
  logic [WORD_WIDTH-1:0]   expired_count_q;

  // A period may only be taken while idle and not being cancelled or reset.
  assign period_ready = (state == IDLE) && !abort && !clear;

  assign running       = running_q;
  assign expired_valid = expired_valid_q;
  assign remaining     = remaining_q;
  assign expired_count = expired_count_q;

  // State machine, countdown and token counter; priority is clear, abort,
  // then the per-state behaviour. Status flags are registered alongside state.
  always_ff @(posedge clock) begin
    if (clear) begin
      state           <= IDLE;
      running_q       <= 1'b0;
      expired_valid_q <= 1'b0;
      remaining_q     <= ZERO;
      expired_count_q <= ZERO;
    end else if (abort) begin
      // No token and no count change, whatever else happens this cycle.
      state           <= IDLE;
      running_q       <= 1'b0;
      expired_valid_q <= 1'b0;
      remaining_q     <= ZERO;
    end else begin
      unique case (state)
        IDLE: begin
          if (period_valid) begin
            if (period <= ONE) begin
              // Zero is treated as one: expire on the very next edge.
              state           <= DONE;
              running_q       <= 1'b0;
              expired_valid_q <= 1'b1;
              remaining_q     <= ZERO;
            end else begin
              state           <= RUN;
              running_q       <= 1'b1;
              expired_valid_q <= 1'b0;
              remaining_q     <= period;
            end
          end
        end
        RUN: begin
          if (remaining_q <= ONE) begin
            // Guarding with <= keeps the count from ever wrapping below zero.
            state           <= DONE;
            running_q       <= 1'b0;
            expired_valid_q <= 1'b1;
            remaining_q     <= ZERO;
          end else begin
            remaining_q <= remaining_q - ONE;
          end
        end
        DONE: begin
          if (expired_ready) begin
            state           <= IDLE;
            running_q       <= 1'b0;
            expired_valid_q <= 1'b0;
            expired_count_q <= expired_count_q + ONE;
          end
        end
        default: begin
          state           <= IDLE;
          running_q       <= 1'b0;
          expired_valid_q <= 1'b0;
          remaining_q     <= ZERO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_oneshot_handshake.sv
// Directed bench for timer_oneshot_handshake: a 20-bit instance for the
// functional sequence and a 4-bit instance for counter wrap-around.
module tb_timer_oneshot_handshake;

  logic        clock = 1'b0;
  logic        clear;
  int          checks = 0;
  int          errors = 0;

  // 20-bit instance
  logic        period_valid, period_ready, abort, expired_valid, expired_ready, running;
  logic [19:0] period, remaining, expired_count;

  // 4-bit instance
  logic        period_valid4, period_ready4, abort4, expired_valid4, expired_ready4, running4;
  logic [3:0]  period4, remaining4, expired_count4;

  always #5 clock = ~clock;

  timer_oneshot_handshake #(.WORD_WIDTH(20)) dut (
    .clock(clock), .clear(clear),
    .period_valid(period_valid), .period_ready(period_ready), .period(period),
    .abort(abort),
    .expired_valid(expired_valid), .expired_ready(expired_ready),
    .running(running), .remaining(remaining), .expired_count(expired_count)
  );

  timer_oneshot_handshake #(.WORD_WIDTH(4)) dut4 (
    .clock(clock), .clear(clear),
    .period_valid(period_valid4), .period_ready(period_ready4), .period(period4),
    .abort(abort4),
    .expired_valid(expired_valid4), .expired_ready(expired_ready4),
    .running(running4), .remaining(remaining4), .expired_count(expired_count4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    clear = 1'b1;
    period_valid = 1'b0; period = '0; abort = 1'b0; expired_ready = 1'b0;
    period_valid4 = 1'b0; period4 = '0; abort4 = 1'b0; expired_ready4 = 1'b1;

    // Reset state
    step();
    chk("rst_remaining", remaining, 0);
    chk("rst_count", expired_count, 0);
    chk("rst_valid", expired_valid, 0);
    chk("rst_running", running, 0);
    chk("rst_ready_during_clear", period_ready, 0);
    chk("rst4_count", expired_count4, 0);
    clear = 1'b0;
    #1;
    chk("ready_after_clear", period_ready, 1);

    // Basic count of 5
    expired_ready = 1'b1;
    period = 20'd5; period_valid = 1'b1;
    step();
    period_valid = 1'b0;
    chk("basic_rem_5", remaining, 5);
    chk("basic_running", running, 1);
    chk("basic_ready_busy", period_ready, 0);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("basic_rem_dec", remaining, 32'(5 - k));
      chk("basic_valid_low", expired_valid, 0);
    end
    step();
    chk("basic_expired", expired_valid, 1);
    chk("basic_rem_0", remaining, 0);
    chk("basic_not_running", running, 0);
    step();
    chk("basic_valid_cleared", expired_valid, 0);
    chk("basic_count_1", expired_count, 1);
    chk("basic_ready_again", period_ready, 1);

    // Period 0 then period 1
    period = 20'd0; period_valid = 1'b1;
    step();
    period_valid = 1'b0;
    chk("zero_expired", expired_valid, 1);
    chk("zero_not_running", running, 0);
    chk("zero_rem", remaining, 0);
    step();
    chk("zero_count", expired_count, 2);
    period = 20'd1; period_valid = 1'b1;
    step();
    period_valid = 1'b0;
    chk("one_expired", expired_valid, 1);
    chk("one_not_running", running, 0);
    step();
    chk("one_count", expired_count, 3);
    chk("one_valid_cleared", expired_valid, 0);

    // Backpressure with period 3
    expired_ready = 1'b0;
    period = 20'd3; period_valid = 1'b1;
    step();
    period_valid = 1'b0;
    chk("bp_rem_3", remaining, 3);
    step();
    step();
    chk("bp_rem_1", remaining, 1);
    step();
    period = 20'd7; period_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("bp_valid_held", expired_valid, 1);
      chk("bp_ready_low", period_ready, 0);
      chk("bp_rem_zero", remaining, 0);
      step();
    end
    period_valid = 1'b0;
    expired_ready = 1'b1;
    #1;
    chk("bp_count_unchanged", expired_count, 3);
    step();
    chk("bp_count_inc", expired_count, 4);
    chk("bp_valid_cleared", expired_valid, 0);
    chk("bp_no_load", running, 0);
    chk("bp_rem_no_load", remaining, 0);

    // Abort when remaining == 1
    period = 20'd2; period_valid = 1'b1;
    step();
    period_valid = 1'b0;
    step();
    chk("ab1_rem_1", remaining, 1);
    abort = 1'b1;
    #1;
    chk("ab1_ready_low", period_ready, 0);
    step();
    abort = 1'b0;
    chk("ab1_no_token", expired_valid, 0);
    chk("ab1_idle", running, 0);
    chk("ab1_rem_0", remaining, 0);
    step();
    chk("ab1_still_no_token", expired_valid, 0);
    chk("ab1_count", expired_count, 4);

    // Abort in DONE together with expired_ready
    period = 20'd1; period_valid = 1'b1;
    step();
    period_valid = 1'b0;
    chk("ab2_done", expired_valid, 1);
    abort = 1'b1; expired_ready = 1'b1;
    step();
    abort = 1'b0;
    chk("ab2_no_inc", expired_count, 4);
    chk("ab2_valid_cleared", expired_valid, 0);
    #1;
    chk("ab2_ready_again", period_ready, 1);

    // Abort in IDLE together with period_valid
    abort = 1'b1; period = 20'd5; period_valid = 1'b1;
    #1;
    chk("ab3_ready_low", period_ready, 0);
    step();
    abort = 1'b0; period_valid = 1'b0;
    chk("ab3_no_load_running", running, 0);
    chk("ab3_no_load_rem", remaining, 0);
    step();
    chk("ab3_no_token", expired_valid, 0);

    // Reset mid-run
    period = 20'd100; period_valid = 1'b1;
    step();
    period_valid = 1'b0;
    chk("mid_rem_100", remaining, 100);
    for (int k = 0; k < 60; k++) step();
    chk("mid_rem_40", remaining, 40);
    clear = 1'b1;
    step();
    chk("mid_rem_0", remaining, 0);
    chk("mid_valid_0", expired_valid, 0);
    chk("mid_count_0", expired_count, 0);
    chk("mid_running_0", running, 0);
    chk("mid_ready_in_clear", period_ready, 0);
    clear = 1'b0;
    #1;
    chk("mid_ready_after", period_ready, 1);

    // Wrap on the 4-bit instance: sixteen tokens of period 2
    for (int i = 1; i <= 16; i++) begin
      period4 = 4'd2; period_valid4 = 1'b1;
      step();
      period_valid4 = 1'b0;
      chk("wrap_rem_2", remaining4, 2);
      step();
      chk("wrap_rem_1", remaining4, 1);
      step();
      chk("wrap_valid", expired_valid4, 1);
      step();
      chk("wrap_count", expired_count4, 32'(i % 16));
      chk("wrap_ready", period_ready4, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
